ysyx_24110015_mem_responder: RTL and testbench
==============================================

# ysyx_24110015_mem_responder

Memory-side responder for the core's instruction-fetch and load/store requests: accepts one request at a time over a valid/ready channel, performs a word-wide read or byte-masked write on an internal array, and returns the response after a fixed, parameterised latency. It sits opposite the IFU/LSU request ports, replacing the combinational DPI memory path so that multi-cycle fetch/access can be exercised by the controller.

## Interface
Parameters:
- ADDR_W, 10, word-address bits; array depth 2^ADDR_W 32-bit words
- LATENCY, 1, cycles from request acceptance to rsp_valid; legal range 1..15

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  reset, synchronous, active-low (asserted when 0, sampled at posedge clk)
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request this cycle
- req_addr  in  32  byte address; bits [1:0] ignored, bits [ADDR_W+1:2] index the array, upper bits ignored
- req_wen  in  1  1 = write, 0 = read
- req_wdata  in  32  write data
- req_wmask  in  4  byte-lane enables for writes, bit i → wdata[8i+7:8i]
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts response
- rsp_rdata  out  32  read data; 32'h0 for write responses

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready = 1. On req_valid & req_ready (accept edge T): latch read data (mem[idx]) into response register, or perform masked write and load response register with 0. If LATENCY = 1 → RESP, else → WAIT with counter loaded to LATENCY-1.
- WAIT: req_ready = 0, counter decrements each cycle; when counter reaches 1 (i.e. LATENCY-1 cycles spent) → RESP.
- RESP: rsp_valid = 1, rsp_rdata stable and held until rsp_valid & rsp_ready; then → IDLE.
- Single outstanding transaction; req_ready = 0 in WAIT and RESP, so requests presented then are not accepted and must be held by the requester.
- Read data is a snapshot at the accept edge; no other write can alter it (single outstanding).
- Write with req_wmask = 4'b0000: no array change, response still returned.
- Address aliasing: addresses differing only in bits above ADDR_W+1 hit the same word; misaligned addresses access the containing aligned word.
- Array contents are not reset; write effects are permanent across reset.

## Timing
- Reset (rst = 0 at a posedge): state IDLE, counter 0, rsp_valid 0, rsp_rdata 32'h0; req_ready forced 0 while rst = 0, 1 on first cycle after release.
- Reset mid-transaction: pending response dropped, no rsp_valid after release; a write accepted before reset remains in the array.
- Latency: accept at edge T → rsp_valid high in cycle following edge T+LATENCY-1 (LATENCY = 1: rsp_valid visible the cycle immediately after acceptance).
- Throughput: response handshake at edge H → IDLE after H → next accept no earlier than edge H+1; max one transaction per LATENCY+1 cycles with rsp_ready held high.
- rsp_ready low in RESP: stall indefinitely, rsp_valid and rsp_rdata unchanged.
- req_ready and rsp_valid are state decodes only (no combinational path from req_valid/rsp_ready).

## Structure
- Shared header/package ysyx_24110015_defs: FSM state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2), data width 32, mask width 4.
- Sub-module ysyx_24110015_mem_array: 2^ADDR_W × 32 storage, one synchronous byte-masked write port and one read port used at the accept edge; optional $readmemh preload for simulation.
- Top holds FSM, latency counter (4 bits) and response register.

## Test plan
- Reset: hold rst = 0 for 3 cycles with req_valid = 1 → req_ready = 0, rsp_valid = 0, rsp_rdata = 0; after release req_ready = 1.
- LATENCY = 1 write 32'hDEADBEEF to 0x80000010 mask 4'hF, then read 0x80000010 → rsp_rdata = 32'hDEADBEEF exactly one cycle after each acceptance; write response rdata = 0.
- Masked write: word = 32'h11223344, write 32'hAABBCCDD mask 4'b0101 → read returns 32'h11BB33DD; mask 4'b0000 leaves word unchanged.
- LATENCY = 4, rsp_ready tied 1, back-to-back reads → rsp_valid 4 cycles after each accept, accepts spaced 5 cycles, req_ready low throughout WAIT/RESP.
- Backpressure: rsp_ready = 0 for 6 cycles in RESP → rsp_valid and rsp_rdata constant, new req_valid not accepted; release → one handshake, return to IDLE.
- Reset during WAIT after a write to 0x20 → no response after release; subsequent read of 0x20 returns written value; aliasing read of 0x20 + 2^(ADDR_W+2) returns same value.

Source files
------------

// File: rtl/ysyx_24110015_defs.sv
// Shared definitions for the memory responder: FSM encodings and data/mask widths.
package ysyx_24110015_defs;

    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/ysyx_24110015_mem_array.sv
// Word-wide storage with one synchronous byte-masked write port and a
// combinational read port sharing the same index.
import ysyx_24110015_defs::*;

module ysyx_24110015_mem_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wmask,
    output logic [31:0]       rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: storage has no reset branch; contents survive reset and a reset
    // loop over the whole array would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (wmask[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/ysyx_24110015_mem_responder.sv
// Single-outstanding memory responder: accepts a read or masked write, then
// returns the response after LATENCY cycles over a valid/ready channel.
import ysyx_24110015_defs::*;

module ysyx_24110015_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic [ADDR_W-1:0] idx;
    logic        unused_addr_bits;

    // Byte offset and bits above the array index are ignored, so aliases and
    // misaligned addresses land on the containing word.
    assign idx              = req_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

    ysyx_24110015_mem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .we    (mem_we),
        .idx   (idx),
        .wdata (req_wdata),
        .wmask (req_wmask),
        .rdata (mem_rdata)
    );

    assign req_ready = (state_q == IDLE) && rst;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    mem_we  = req_wen;
                    rdata_d = req_wen ? 32'h0 : mem_rdata;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_ysyx_24110015_mem_responder.sv
// Directed bench: instance 0 runs LATENCY=1, instance 1 runs LATENCY=4.
module tb_ysyx_24110015_mem_responder;

    localparam int ADDR_W = 10;
    localparam int LAT [2] = '{1, 4};

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_addr  [2];
    logic        req_wen   [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wmask [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];

    int n_checks = 0;
    int n_fail   = 0;
    int proto_err;

    always #5 clk = ~clk;

    ysyx_24110015_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .req_wen(req_wen[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0])
    );

    ysyx_24110015_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(4)) u_dut_l4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .req_wen(req_wen[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Full transaction with rsp_ready held high. Entered and left 1ns after a
    // posedge. n = edges after the accept edge before rsp_valid was seen.
    task automatic do_req(input int d, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wmask,
                          output logic [31:0] rdata, output int n, output longint t_acc);
        req_valid[d] = 1'b1;
        req_wen[d]   = wen;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_wmask[d] = wmask;
        for (int k = 0; k < 20 && !req_ready[d]; k++) begin
            @(posedge clk); #1;
        end
        if (!req_ready[d]) check("accept_timeout", 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        t_acc = longint'($time);
        #1;
        req_valid[d] = 1'b0;
        n = 0;
        while (!rsp_valid[d] && n < 40) begin
            if (req_ready[d]) proto_err++;
            @(posedge clk); #1;
            n++;
        end
        if (req_ready[d]) proto_err++;
        rdata = rsp_rdata[d];
        @(posedge clk); #1;
        if (rsp_valid[d]) proto_err++;
    endtask

    initial begin
        logic [31:0] rd, held;
        int          n;
        longint      t0, t1;
        int          stable_err, extra;

        proto_err = 0;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b1;
            req_addr[d]  = 32'h0;
            req_wen[d]   = 1'b0;
            req_wdata[d] = 32'h0;
            req_wmask[d] = 4'h0;
            rsp_ready[d] = 1'b1;
        end

        // Reset held 3 cycles with a request pending
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready[0]), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        check("rst_rsp_rdata", rsp_rdata[0], 32'h0);
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        rst = 1'b1;
        #1;
        check("rel_req_ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk); #1;

        // LATENCY=1 full write then read
        do_req(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, rd, n, t0);
        check("l1_wr_lat", 32'(n), 32'd0);
        check("l1_wr_rdata", rd, 32'h0);
        do_req(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, n, t1);
        check("l1_rd_lat", 32'(n), 32'd0);
        check("l1_rd_data", rd, 32'hDEAD_BEEF);
        check("l1_spacing", 32'(t1 - t0), 32'd20);

        // Byte-masked writes
        do_req(0, 1'b1, 32'h40, 32'h1122_3344, 4'hF, rd, n, t0);
        do_req(0, 1'b1, 32'h40, 32'hAABB_CCDD, 4'b0101, rd, n, t0);
        do_req(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, n, t0);
        check("mask_0101", rd, 32'h11BB_33DD);
        do_req(0, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'b0000, rd, n, t0);
        check("mask_0000_rsp", rd, 32'h0);
        do_req(0, 1'b0, 32'h43, 32'h0, 4'h0, rd, n, t0);
        check("mask_0000_misalign", rd, 32'h11BB_33DD);
        do_req(0, 1'b1, 32'h44, 32'h0000_00A5, 4'b0001, rd, n, t0);
        do_req(0, 1'b1, 32'h44, 32'h7700_0000, 4'b1000, rd, n, t0);
        do_req(0, 1'b0, 32'h44, 32'h0, 4'h0, rd, n, t0);
        check("mask_lane0_lane3", rd & 32'hFF00_00FF, 32'h7700_00A5);

        // LATENCY=4 back-to-back reads
        do_req(1, 1'b1, 32'h100, 32'hCAFE_F00D, 4'hF, rd, n, t0);
        check("l4_wr_lat", 32'(n), 32'd3);
        do_req(1, 1'b1, 32'h104, 32'h1234_5678, 4'hF, rd, n, t0);
        do_req(1, 1'b0, 32'h100, 32'h0, 4'h0, rd, n, t0);
        check("l4_rd0_lat", 32'(n), 32'd3);
        check("l4_rd0_data", rd, 32'hCAFE_F00D);
        do_req(1, 1'b0, 32'h104, 32'h0, 4'h0, rd, n, t1);
        check("l4_rd1_lat", 32'(n), 32'd3);
        check("l4_rd1_data", rd, 32'h1234_5678);
        check("l4_spacing", 32'(t1 - t0), 32'd50);
        check("busy_ready_low", 32'(proto_err), 32'd0);

        // Backpressure: response held 6 cycles while a new request waits
        rsp_ready[1] = 1'b0;
        req_valid[1] = 1'b1;
        req_wen[1]   = 1'b0;
        req_addr[1]  = 32'h104;
        @(posedge clk); #1;
        req_addr[1]  = 32'h100;
        n = 0;
        while (!rsp_valid[1] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_lat", 32'(n), 32'd3);
        held = rsp_rdata[1];
        stable_err = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (!rsp_valid[1] || rsp_rdata[1] !== held || req_ready[1]) stable_err++;
        end
        check("bp_held_data", held, 32'h1234_5678);
        check("bp_stable", 32'(stable_err), 32'd0);
        req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(rsp_valid[1]), 32'd0);
        check("bp_release_ready", 32'(req_ready[1]), 32'd1);

        // Reset during WAIT after a write
        req_valid[1] = 1'b1;
        req_wen[1]   = 1'b1;
        req_addr[1]  = 32'h20;
        req_wdata[1] = 32'h5A5A_1234;
        req_wmask[1] = 4'hF;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("midrst_rdata", rsp_rdata[1], 32'h0);
        extra = 0;
        repeat (8) begin
            if (rsp_valid[1]) extra++;
            @(posedge clk); #1;
        end
        check("midrst_no_rsp", 32'(extra), 32'd0);
        do_req(1, 1'b0, 32'h20, 32'h0, 4'h0, rd, n, t0);
        check("midrst_wr_kept", rd, 32'h5A5A_1234);
        do_req(1, 1'b0, 32'h20 + (32'd1 << (ADDR_W + 2)), 32'h0, 4'h0, rd, n, t0);
        check("alias_read", rd, 32'h5A5A_1234);
        check("final_proto", 32'(proto_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
